// File: rtl/mod_updown_counter_pkg.sv
// Purpose : Shared constants and helpers for the up/down counter slice.
// Contents: counting-mode and direction constants, and a ceiling-log2
//           function used to size the prescaler register.
package counter_pkg;

    // SATURATE parameter values
    localparam int CNT_MODE_WRAP = 0;
    localparam int CNT_MODE_SAT  = 1;

    // up_dn encodings
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Ceiling log2; clog2(1) = 0, so callers needing a register clamp to 1 bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Purpose : Control/status bundle of the up/down counter.
// Signals : en, up_dn, clr, load, load_val, ovf_clr (towards the counter)
//           count, tc, ovf                        (from the counter)
// Modports: master = user of the counter, slave = the counter itself.
interface mod_updown_counter_if #(
    parameter int WIDTH = 8
) ();

    logic             en;
    logic             up_dn;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             ovf_clr;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;

    modport master (
        output en, up_dn, clr, load, load_val, ovf_clr,
        input  count, tc, ovf
    );

    modport slave (
        input  en, up_dn, clr, load, load_val, ovf_clr,
        output count, tc, ovf
    );

endinterface

// File: rtl/mod_updown_counter_tick_prescaler.sv
// Purpose : Divides enabled clk cycles into count-step ticks.
// Ports   : clk      - system clock
//           rst      - asynchronous active-high reset
//           en       - advances the divider; low freezes it in place
//           sync_clr - synchronous return of the divider to 0
//           tick     - combinational, high on the last enabled cycle of a period
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    // At least one bit so PRESCALE=1 needs no special case: the divider
    // then sits at 0 permanently and tick reduces to en.
    localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_presc;

    assign tick = en && (r_presc == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (sync_clr) begin
            r_presc <= '0;
        end else if (en) begin
            r_presc <= tick ? '0 : r_presc + PW'(1);
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Purpose : Parametrised up/down counter with prescale, wrap/saturate limits,
//           synchronous clear and load, terminal-count pulse and sticky ovf.
// Ports   : clk - system clock
//           rst - asynchronous active-high reset
//           bus - mod_updown_counter_if.slave (controls in, count/tc/ovf out)
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int              PRESCALE = 1,
    parameter int              SATURATE = CNT_MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    mod_updown_counter_if.slave bus
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "mod_updown_counter: WIDTH must be 1..32");
    end
    if (MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $fatal(1, "mod_updown_counter: MAX_VAL exceeds 2**WIDTH-1");
    end
    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_presc
        $fatal(1, "mod_updown_counter: PRESCALE must be 1..65535");
    end

    localparam logic [WIDTH-1:0] W_MAX = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;
    logic [WIDTH-1:0] w_count_next;
    logic             w_limit;
    logic             w_tick;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_presc (
        .clk      (clk),
        .rst      (rst),
        .en       (bus.en),
        .sync_clr (bus.clr | bus.load),
        .tick     (w_tick)
    );

    // clr > load > tick step > hold. A limit event only exists on a tick
    // that is not overridden by clr or load.
    always_comb begin
        w_count_next = r_count;
        w_limit      = 1'b0;
        if (bus.clr) begin
            w_count_next = '0;
        end else if (bus.load) begin
            w_count_next = (bus.load_val > W_MAX) ? W_MAX : bus.load_val;
        end else if (w_tick) begin
            if (bus.up_dn == DIR_UP) begin
                if (r_count == W_MAX) begin
                    w_limit      = 1'b1;
                    w_count_next = (SATURATE == CNT_MODE_SAT) ? W_MAX : '0;
                end else begin
                    w_count_next = r_count + WIDTH'(1);
                end
            end else begin
                if (r_count == '0) begin
                    w_limit      = 1'b1;
                    w_count_next = (SATURATE == CNT_MODE_SAT) ? '0 : W_MAX;
                end else begin
                    w_count_next = r_count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_tc    <= w_limit;
            // a limit event on the same edge beats ovf_clr
            if (w_limit) begin
                r_ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.count = r_count;
    assign bus.tc    = r_tc;
    assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_mod_updown_counter.sv
module tb_mod_updown_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] count;
        logic       tc;
        logic       ovf;
        string      tag;
    } exp_t;

    exp_t sb[$];

    // A: wrap, prescale 1; B: saturate, prescale 1; C: wrap, prescale 4
    mod_updown_counter_if #(.WIDTH(4)) bus_a ();
    mod_updown_counter_if #(.WIDTH(4)) bus_b ();
    mod_updown_counter_if #(.WIDTH(4)) bus_c ();

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(0))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(1))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(4), .SATURATE(0))
        dut_c (.clk(clk), .rst(rst), .bus(bus_c.slave));

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        bus_a.en = 0; bus_a.up_dn = 0; bus_a.clr = 0; bus_a.load = 0; bus_a.load_val = 0; bus_a.ovf_clr = 0;
        bus_b.en = 0; bus_b.up_dn = 0; bus_b.clr = 0; bus_b.load = 0; bus_b.load_val = 0; bus_b.ovf_clr = 0;
        bus_c.en = 0; bus_c.up_dn = 0; bus_c.clr = 0; bus_c.load = 0; bus_c.load_val = 0; bus_c.ovf_clr = 0;
    endtask

    task automatic sample(input int sel, output logic [3:0] c, output logic t, output logic o);
        case (sel)
            0:       begin c = bus_a.count; t = bus_a.tc; o = bus_a.ovf; end
            1:       begin c = bus_b.count; t = bus_b.tc; o = bus_b.ovf; end
            default: begin c = bus_c.count; t = bus_c.tc; o = bus_c.ovf; end
        endcase
    endtask

    // Drive one cycle on a selected counter, queue the expected outputs,
    // then compare the DUT against the queue head after the edge.
    task automatic step(input int sel, input logic en, input logic up, input logic clr,
                        input logic load, input logic [3:0] lv, input logic oclr,
                        input logic [3:0] ec, input logic et, input logic eo, input string tag);
        exp_t e;
        logic [3:0] c;
        logic t, o;
        idle_all();
        case (sel)
            0: begin bus_a.en = en; bus_a.up_dn = up; bus_a.clr = clr; bus_a.load = load; bus_a.load_val = lv; bus_a.ovf_clr = oclr; end
            1: begin bus_b.en = en; bus_b.up_dn = up; bus_b.clr = clr; bus_b.load = load; bus_b.load_val = lv; bus_b.ovf_clr = oclr; end
            default: begin bus_c.en = en; bus_c.up_dn = up; bus_c.clr = clr; bus_c.load = load; bus_c.load_val = lv; bus_c.ovf_clr = oclr; end
        endcase
        sb.push_back('{count: ec, tc: et, ovf: eo, tag: tag});
        @(posedge clk);
        #1;
        sample(sel, c, t, o);
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, "_count"}, {4'd0, c}, {4'd0, e.count});
            check({e.tag, "_tc"},    {7'd0, t}, {7'd0, e.tc});
            check({e.tag, "_ovf"},   {7'd0, o}, {7'd0, e.ovf});
        end
        $display("step %-10s sel=%0d count=%0d tc=%0d ovf=%0d", tag, sel, c, t, o);
    endtask

    task automatic check_zero(input int sel, input string tag);
        logic [3:0] c;
        logic t, o;
        sample(sel, c, t, o);
        check({tag, "_count"}, {4'd0, c}, 8'd0);
        check({tag, "_tc"},    {7'd0, t}, 8'd0);
        check({tag, "_ovf"},   {7'd0, o}, 8'd0);
    endtask

    initial begin
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        check_zero(0, "rst_a");
        check_zero(1, "rst_b");
        check_zero(2, "rst_c");
        #2 rst = 0;

        // A: count up 12 ticks, wrap 9->0
        for (int i = 1; i <= 12; i++)
            step(0, 1, 1, 0, 0, 4'd0, 0, 4'(i % 10), (i == 10), (i >= 10), "A_up");
        // A: load 3, count down through the 0->9 wrap
        step(0, 0, 0, 0, 1, 4'd3, 0, 4'd3, 0, 1, "A_load3");
        step(0, 1, 0, 0, 0, 4'd0, 0, 4'd2, 0, 1, "A_dn");
        step(0, 1, 0, 0, 0, 4'd0, 0, 4'd1, 0, 1, "A_dn");
        step(0, 1, 0, 0, 0, 4'd0, 0, 4'd0, 0, 1, "A_dn");
        step(0, 1, 0, 0, 0, 4'd0, 0, 4'd9, 1, 1, "A_dnwrap");
        step(0, 1, 0, 0, 0, 4'd0, 0, 4'd8, 0, 1, "A_dn");
        step(0, 0, 0, 0, 1, 4'd14, 0, 4'd9, 0, 1, "A_clamp");
        // clr beats load, and leaves ovf alone
        step(0, 1, 1, 1, 1, 4'd5, 0, 4'd0, 0, 1, "A_clrload");
        // load beats tick
        step(0, 1, 1, 0, 1, 4'd7, 0, 4'd7, 0, 1, "A_loadtick");
        step(0, 0, 0, 0, 1, 4'd0, 0, 4'd0, 0, 1, "A_load0");
        // ovf_clr together with a limit event: set wins
        step(0, 1, 0, 0, 0, 4'd0, 1, 4'd9, 1, 1, "A_ovfsetclr");
        step(0, 0, 0, 0, 0, 4'd0, 1, 4'd9, 0, 0, "A_ovfclr");

        // B: saturating
        step(1, 0, 0, 0, 1, 4'd8, 0, 4'd8, 0, 0, "B_load8");
        step(1, 1, 1, 0, 0, 4'd0, 0, 4'd9, 0, 0, "B_up");
        step(1, 1, 1, 0, 0, 4'd0, 0, 4'd9, 1, 1, "B_sat");
        step(1, 1, 1, 0, 0, 4'd0, 0, 4'd9, 1, 1, "B_sat");
        step(1, 0, 1, 0, 0, 4'd0, 0, 4'd9, 0, 1, "B_hold");
        step(1, 1, 1, 0, 0, 4'd0, 0, 4'd9, 1, 1, "B_sat");
        step(1, 0, 0, 1, 0, 4'd0, 0, 4'd0, 0, 1, "B_clr");
        step(1, 1, 0, 0, 0, 4'd0, 0, 4'd0, 1, 1, "B_sat0");
        step(1, 1, 0, 0, 0, 4'd0, 0, 4'd0, 1, 1, "B_sat0");
        step(1, 1, 1, 0, 0, 4'd0, 0, 4'd1, 0, 1, "B_turn");

        // C: prescale 4
        for (int i = 1; i <= 16; i++)
            step(2, 1, 1, 0, 0, 4'd0, 0, 4'(i / 4), 0, 0, "C_presc");
        step(2, 1, 1, 0, 0, 4'd0, 0, 4'd4, 0, 0, "C_pre1");
        step(2, 1, 1, 0, 0, 4'd0, 0, 4'd4, 0, 0, "C_pre2");
        for (int i = 0; i < 3; i++)
            step(2, 0, 1, 0, 0, 4'd0, 0, 4'd4, 0, 0, "C_frozen");
        step(2, 1, 1, 0, 0, 4'd0, 0, 4'd4, 0, 0, "C_pre3");
        step(2, 1, 1, 0, 0, 4'd0, 0, 4'd5, 0, 0, "C_resume");
        for (int i = 1; i <= 6; i++)
            step(2, 1, 1, 0, 0, 4'd0, 0, (i == 4) ? 4'd6 : ((i < 4) ? 4'd5 : 4'd6), 0, 0, "C_to6");

        // A: make count=9, tc=1, ovf=1 just before the async reset
        step(0, 0, 0, 0, 1, 4'd0, 0, 4'd0, 0, 0, "A_load0b");
        step(0, 1, 0, 0, 0, 4'd0, 0, 4'd9, 1, 1, "A_prerst");

        // async reset between edges: clears without a clk edge
        #2 rst = 1;
        #1;
        check_zero(0, "arst_a");
        check_zero(1, "arst_b");
        check_zero(2, "arst_c");
        #1 rst = 0;

        // C: first step PRESCALE enabled cycles after release
        step(2, 1, 1, 0, 0, 4'd0, 0, 4'd0, 0, 0, "C_post1");
        step(2, 1, 1, 0, 0, 4'd0, 0, 4'd0, 0, 0, "C_post2");
        step(2, 1, 1, 0, 0, 4'd0, 0, 4'd0, 0, 0, "C_post3");
        step(2, 1, 1, 0, 0, 4'd0, 0, 4'd1, 0, 0, "C_post4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
